// File: rtl/nsa_pkg.sv
// nsa_pkg: shared types and constants for the nibble-serial adder controller.
//   state_t : controller FSM states (IDLE, RUN, DONE)
//   NIB_W   : width of the time-shared adder slice
//   cnt_w   : nibble-counter width for a given nibble count (minimum 1)
package nsa_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for n nibbles; a single-nibble build still needs one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_adder.sv
// nibble_adder: combinational 4-bit ripple-carry slice built from full-adder cells.
//   a, b : nibble operands
//   cin  : carry into bit 0
//   sum  : nibble result
//   cout : carry out of bit 3
module nibble_adder
    import nsa_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit, carry rippling upward.
    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds two WIDTH-bit unsigned operands one nibble per
// clock through a single shared 4-bit slice, LSB nibble first, carry held in a
// register between nibbles. Result latency is WIDTH/4 cycles after acceptance.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout)
//   busy                 : high while an operation is in RUN or DONE
// Build option: define NSA_SAT_EN to saturate sum to all ones when the final
// carry is set (cout still reports 1). Without it sum is modulo 2^WIDTH.
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned N_NIB = WIDTH / NIB_W;
    localparam int unsigned CNT_W = cnt_w(N_NIB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_NIB - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               in_ready_q;

    logic [NIB_W-1:0]   nib_sum_c;
    logic               nib_cout_c;

    // Operands shift right each RUN cycle, so the current nibble is always at the bottom.
    nibble_adder u_slice (
        .a    (a_q[NIB_W-1:0]),
        .b    (b_q[NIB_W-1:0]),
        .cin  (carry_q),
        .sum  (nib_sum_c),
        .cout (nib_cout_c)
    );

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= RUN;
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                    end else begin
                        // First cycle after reset release raises in_ready here.
                        in_ready_q <= 1'b1;
                    end
                end

                RUN: begin
                    sum_q[cnt_q*NIB_W +: NIB_W] <= nib_sum_c;
                    carry_q <= nib_cout_c;
                    a_q     <= a_q >> NIB_W;
                    b_q     <= b_q >> NIB_W;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        cout_q      <= nib_cout_c;
                        out_valid_q <= 1'b1;
`ifdef NSA_SAT_EN
                        // Overrides the top-nibble write above when the result overflows.
                        if (nib_cout_c) begin
                            sum_q <= '1;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl: a WIDTH=32 instance and a WIDTH=4
// instance sharing clock and reset. Expected values are hand-computed.
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [31:0] a, b, sum;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0]  a4, b4, sum4;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    nibble_serial_adder_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    always #5 clk = ~clk;

`ifdef NSA_SAT_EN
    localparam logic [31:0] OVF_SUM = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OVF_SUM = 32'h0000_0000;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    int          n;
    int          acc_cyc[2];
    int          n_acc;
    logic [31:0] res_sum[2];
    logic        res_cout[2];
    int          n_res;
    logic        acc_now;
    logic [31:0] hold_sum;
    logic        hold_cout;

    initial begin
        rst = 1'b1;
        in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 0;
        in_valid4 = 0; a4 = '0; b4 = '0; cin4 = 0; out_ready4 = 0;

        // Reset state
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Overflow: FFFFFFFF + 1, exact 8-cycle latency
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 0; in_valid = 1;
        tick();
        in_valid = 0;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_in_ready", 64'(in_ready), 64'd0);
        repeat (7) tick();
        chk("t1_valid_early", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_sum", 64'(sum), 64'(OVF_SUM));
        chk("t1_cout", 64'(cout), 64'd1);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("t1_hs_valid", 64'(out_valid), 64'd0);
        chk("t1_hs_busy", 64'(busy), 64'd0);
        chk("t1_hs_in_ready", 64'(in_ready), 64'd1);

        // 0x12345678 + 0x11111111 + 1, busy throughout
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1; in_valid = 1;
        tick();
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 20) begin
            chk("t2_busy_run", 64'(busy), 64'd1);
            tick();
            n++;
        end
        chk("t2_latency", 64'(n), 64'd8);
        chk("t2_sum", 64'(sum), 64'h2345_678A);
        chk("t2_cout", 64'(cout), 64'd0);
        chk("t2_busy_done", 64'(busy), 64'd1);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("t2_busy_after", 64'(busy), 64'd0);

        // Back-pressure with new operands held valid
        a = 32'hA0A0_A0A0; b = 32'h0505_0505; cin = 0; in_valid = 1;
        tick();
        in_valid = 0;
        repeat (8) tick();
        chk("t3_valid", 64'(out_valid), 64'd1);
        hold_sum = sum; hold_cout = cout;
        chk("t3_sum", 64'(sum), 64'hA5A5_A5A5);
        a = 32'h0000_0003; b = 32'h0000_0004; cin = 0; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_bp_valid", 64'(out_valid), 64'd1);
            chk("t3_bp_sum", 64'(sum), 64'(hold_sum));
            chk("t3_bp_cout", 64'(cout), 64'(hold_cout));
            chk("t3_bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("t3_hs_in_ready", 64'(in_ready), 64'd1);
        chk("t3_hs_busy", 64'(busy), 64'd0);
        tick();
        in_valid = 0;
        chk("t3_accept_busy", 64'(busy), 64'd1);
        repeat (8) tick();
        chk("t3_new_valid", 64'(out_valid), 64'd1);
        chk("t3_new_sum", 64'(sum), 64'h0000_0007);
        out_ready = 1;
        tick();
        out_ready = 0;

        // Async reset mid-RUN after nibble 3
        a = 32'h1111_1111; b = 32'h1111_1111; cin = 0; in_valid = 1;
        tick();
        in_valid = 0;
        repeat (4) tick();
        chk("t4_partial_sum", 64'(sum), 64'h0000_2222);
        rst = 1'b1;
        #1;
        chk("t4_rst_valid", 64'(out_valid), 64'd0);
        chk("t4_rst_sum", 64'(sum), 64'd0);
        chk("t4_rst_cout", 64'(cout), 64'd0);
        chk("t4_rst_busy", 64'(busy), 64'd0);
        chk("t4_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t4_rel_in_ready", 64'(in_ready), 64'd1);
        a = 32'h1; b = 32'h1; cin = 0; in_valid = 1;
        tick();
        in_valid = 0;
        repeat (8) tick();
        chk("t4_valid", 64'(out_valid), 64'd1);
        chk("t4_sum", 64'(sum), 64'h2);
        out_ready = 1;
        tick();
        out_ready = 0;

        // Back-to-back with out_ready tied high
        out_ready = 1;
        a = 32'h0000_000F; b = 32'h0000_0001; cin = 0; in_valid = 1;
        n_acc = 0; n_res = 0;
        for (int i = 0; i < 40 && n_res < 2; i++) begin
            acc_now = in_valid && in_ready;
            if (out_valid && n_res < 2) begin
                res_sum[n_res] = sum;
                res_cout[n_res] = cout;
                n_res++;
            end
            tick();
            if (acc_now && n_acc < 2) begin
                acc_cyc[n_acc] = i;
                n_acc++;
                if (n_acc == 1) begin
                    a = 32'h8000_0000; b = 32'h8000_0000;
                end else begin
                    in_valid = 0;
                end
            end
        end
        in_valid = 0;
        out_ready = 0;
        chk("t5_n_acc", 64'(n_acc), 64'd2);
        chk("t5_n_res", 64'(n_res), 64'd2);
        if (n_acc == 2) chk("t5_interval", 64'(acc_cyc[1] - acc_cyc[0]), 64'd10);
        if (n_res == 2) begin
            chk("t5_sum0", 64'(res_sum[0]), 64'h0000_0010);
            chk("t5_cout0", 64'(res_cout[0]), 64'd0);
            chk("t5_sum1", 64'(res_sum[1]), 64'(OVF_SUM));
            chk("t5_cout1", 64'(res_cout[1]), 64'd1);
        end

        // WIDTH=4 instance: F + F + 1 = 0x1F
        a4 = 4'hF; b4 = 4'hF; cin4 = 1; in_valid4 = 1;
        chk("w4_in_ready", 64'(in_ready4), 64'd1);
        tick();
        in_valid4 = 0;
        chk("w4_valid_early", 64'(out_valid4), 64'd0);
        chk("w4_busy", 64'(busy4), 64'd1);
        tick();
        chk("w4_valid", 64'(out_valid4), 64'd1);
        chk("w4_sum", 64'(sum4), 64'hF);
        chk("w4_cout", 64'(cout4), 64'd1);
        out_ready4 = 1;
        tick();
        out_ready4 = 0;
        chk("w4_hs_valid", 64'(out_valid4), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
